// File: rtl/led_game_scheduler.sv
// led_game_scheduler
// Round sequencer for the LED reaction game. A single lit LED steps across
// the 10-LED bar at a rate set by the current level. Switch presses are
// judged against the lit LED. The block keeps the BCD score, the level and
// the miss count, and declares game over after too many misses.
//
// Optional build macro: LED_GAME_BOUNCE_EN
//   When defined, the LED moves back and forth (9..0..9) instead of
//   wrapping from 0 back to 9.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   starts a new game from IDLE or OVER
//   switch      in   player switches (10), already synchronised
//   led         out  LED bar drive (10)
//   score_tens  out  BCD tens digit of the score
//   score_ones  out  BCD ones digit of the score
//   level       out  current level, 0..MAX_LEVEL
//   state       out  IDLE=0 RUN=1 HIT=2 MISS=3 LEVEL_UP=4 OVER=5
//   game_over   out  high only in OVER
module led_game_scheduler #(
    parameter int TICK_BASE      = 8,
    parameter int TICK_W         = 24,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_MISSES     = 3,
    parameter int MAX_LEVEL      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  switch,
    output logic [9:0]  led,
    output logic [3:0]  score_tens,
    output logic [3:0]  score_ones,
    output logic [1:0]  level,
    output logic [2:0]  state,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_HIT      = 3'd2;
    localparam logic [2:0] S_MISS     = 3'd3;
    localparam logic [2:0] S_LEVEL_UP = 3'd4;
    localparam logic [2:0] S_OVER     = 3'd5;

    localparam int HIT_W  = $clog2(HITS_PER_LEVEL + 1);
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    logic [TICK_W-1:0] tick, tick_n, period;
    logic [3:0]        pos, pos_n;
    logic [9:0]        sw_q;
    logic [HIT_W-1:0]  hits, hits_n;
    logic [MISS_W-1:0] misses, misses_n;
    logic [2:0]        state_n;
    logic [9:0]        led_n;
    logic [3:0]        tens_n, ones_n;
    logic [1:0]        level_n;
    logic              press, tick_done, reload;
`ifdef LED_GAME_BOUNCE_EN
    logic              dir_down, dir_down_n;
`endif

    // Step period halves with each level but never drops below one cycle.
    always_comb begin
        period = TICK_W'(TICK_BASE) >> level;
        if (period == '0)
            period = TICK_W'(1);
    end

    // A press is a new nonzero pattern; a held pattern only counts once.
    assign press     = (switch != 10'd0) && (switch != sw_q);
    assign tick_done = (tick == period - TICK_W'(1));

    // Next-state logic. A press in RUN takes priority over a tick, so the
    // press is judged against the LED currently shown, not the stepped one.
    always_comb begin
        state_n  = state;
        tick_n   = tick;
        pos_n    = pos;
        hits_n   = hits;
        misses_n = misses;
        tens_n   = score_tens;
        ones_n   = score_ones;
        level_n  = level;
        reload   = 1'b0;
`ifdef LED_GAME_BOUNCE_EN
        dir_down_n = dir_down;
`endif
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_n  = S_RUN;
                    tens_n   = 4'd0;
                    ones_n   = 4'd0;
                    level_n  = 2'd0;
                    hits_n   = '0;
                    misses_n = '0;
                    reload   = 1'b1;
                end
            end
            S_RUN: begin
                if (press) begin
                    state_n = (switch == led) ? S_HIT : S_MISS;
                end else if (tick_done) begin
                    tick_n = '0;
`ifdef LED_GAME_BOUNCE_EN
                    if (dir_down) begin
                        if (pos == 4'd0) begin
                            pos_n      = 4'd1;
                            dir_down_n = 1'b0;
                        end else begin
                            pos_n = pos - 4'd1;
                        end
                    end else begin
                        if (pos == 4'd9) begin
                            pos_n      = 4'd8;
                            dir_down_n = 1'b1;
                        end else begin
                            pos_n = pos + 4'd1;
                        end
                    end
`else
                    pos_n = (pos == 4'd0) ? 4'd9 : pos - 4'd1;
`endif
                end else begin
                    tick_n = tick + TICK_W'(1);
                end
            end
            S_HIT: begin
                if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
                    if (score_ones == 4'd9) begin
                        ones_n = 4'd0;
                        tens_n = score_tens + 4'd1;
                    end else begin
                        ones_n = score_ones + 4'd1;
                    end
                end
                hits_n  = hits + HIT_W'(1);
                state_n = (hits_n == HIT_W'(HITS_PER_LEVEL)) ? S_LEVEL_UP : S_RUN;
                reload  = 1'b1;
            end
            S_LEVEL_UP: begin
                level_n = (level == 2'(MAX_LEVEL)) ? level : level + 2'd1;
                hits_n  = '0;
                state_n = S_RUN;
            end
            S_MISS: begin
                misses_n = misses + MISS_W'(1);
                state_n  = (misses_n == MISS_W'(MAX_MISSES)) ? S_OVER : S_RUN;
                reload   = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Every new round starts at the top of the bar heading down.
        if (reload) begin
            pos_n  = 4'd9;
            tick_n = '0;
`ifdef LED_GAME_BOUNCE_EN
            dir_down_n = 1'b1;
`endif
        end

        case (state_n)
            S_RUN, S_HIT, S_MISS, S_LEVEL_UP: led_n = 10'd1 << pos_n;
            S_OVER:                           led_n = 10'h3FF;
            default:                          led_n = 10'd0;
        endcase
    end

    // All game state and outputs are registered together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            led        <= 10'd0;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            level      <= 2'd0;
            game_over  <= 1'b0;
            tick       <= '0;
            pos        <= 4'd0;
            sw_q       <= 10'd0;
            hits       <= '0;
            misses     <= '0;
`ifdef LED_GAME_BOUNCE_EN
            dir_down   <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            led        <= led_n;
            score_tens <= tens_n;
            score_ones <= ones_n;
            level      <= level_n;
            game_over  <= (state_n == S_OVER);
            tick       <= tick_n;
            pos        <= pos_n;
            sw_q       <= switch;
            hits       <= hits_n;
            misses     <= misses_n;
`ifdef LED_GAME_BOUNCE_EN
            dir_down   <= dir_down_n;
`endif
        end
    end

endmodule

// File: tb/tb_led_game_scheduler.sv
// tb_led_game_scheduler
// Scoreboard bench for led_game_scheduler. Each scenario task pushes the
// expected packed output word {led, tens, ones, level, state, game_over}
// as it drives stimulus, then pops and compares once the DUT has updated.
module tb_led_game_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] switch = 10'd0;
    logic [9:0] led;
    logic [3:0] score_tens, score_ones;
    logic [1:0] level;
    logic [2:0] state;
    logic       game_over;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [23:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    led_game_scheduler dut (
        .clock(clock), .reset(reset), .start(start), .switch(switch),
        .led(led), .score_tens(score_tens), .score_ones(score_ones),
        .level(level), .state(state), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Safety net so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [23:0] pk(logic [9:0] l, logic [3:0] t, logic [3:0] o,
                                       logic [1:0] lv, logic [2:0] s, logic g);
        return {l, t, o, lv, s, g};
    endfunction

    function automatic logic [23:0] outs();
        return {led, score_tens, score_ones, level, state, game_over};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reset pulse followed by a one-cycle start: leaves RUN at pos 9, tick 0.
    task automatic new_game();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        switch = 10'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        sb.push_back('{"reset_async", pk(10'd0, 4'd0, 4'd0, 2'd0, 3'd0, 1'b0)});
        #2;
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"reset_held", pk(10'd0, 4'd0, 4'd0, 2'd0, 3'd0, 1'b0)});
        step(2);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        reset = 1'b0;
        sb.push_back('{"idle_no_start", pk(10'd0, 4'd0, 4'd0, 2'd0, 3'd0, 1'b0)});
        step(3);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
    endtask

    task automatic test_step_wrap();
        sb.push_back('{"start_pos9", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        new_game();
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"step7_pos9", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(7);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"step8_pos8", pk(10'h100, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
`ifdef LED_GAME_BOUNCE_EN
        sb.push_back('{"step80_bounce", pk(10'h002, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
`else
        sb.push_back('{"step80_wrap", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
`endif
        step(72);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
    endtask

    task automatic test_hit();
        new_game();
        sb.push_back('{"at_pos3", pk(10'h008, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(48);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        switch = 10'h008;
        sb.push_back('{"hit_state", pk(10'h008, 4'd0, 4'd0, 2'd0, 3'd2, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"hit_to_run", pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"held_no_rehit", pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
        step(3);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        switch = 10'd0;
    endtask

    task automatic test_levels();
        logic [9:0] cur_led;
        logic [1:0] lv;
        cur_led = 10'h200;
        lv = 2'd0;
        new_game();
        for (int k = 1; k <= 10; k++) begin
            switch = cur_led;
            sb.push_back('{$sformatf("lvl_hit%0d", k),
                           pk(cur_led, 4'((k-1)/10), 4'((k-1)%10), lv, 3'd2, 1'b0)});
            step(1);
            e = sb.pop_front(); n_cmp++;
            if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
            switch = 10'd0;
            if (k % 4 == 0) begin
                sb.push_back('{$sformatf("lvl_up%0d", k),
                               pk(10'h200, 4'(k/10), 4'(k%10), lv, 3'd4, 1'b0)});
                step(1);
                e = sb.pop_front(); n_cmp++;
                if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
                lv = lv + 2'd1;
            end
            sb.push_back('{$sformatf("lvl_run%0d", k),
                           pk(10'h200, 4'(k/10), 4'(k%10), lv, 3'd1, 1'b0)});
            step(1);
            e = sb.pop_front(); n_cmp++;
            if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
            cur_led = 10'h200;
            if (k == 4) begin
                sb.push_back('{"lvl1_step3", pk(10'h200, 4'd0, 4'd4, 2'd1, 3'd1, 1'b0)});
                step(3);
                e = sb.pop_front(); n_cmp++;
                if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
                sb.push_back('{"lvl1_step4", pk(10'h100, 4'd0, 4'd4, 2'd1, 3'd1, 1'b0)});
                step(1);
                e = sb.pop_front(); n_cmp++;
                if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
                cur_led = 10'h100;
            end
        end
    endtask

    task automatic test_over();
        new_game();
        switch = 10'h200;
        step(1);
        switch = 10'd0;
        sb.push_back('{"pre_miss_score", pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        for (int m = 1; m <= 3; m++) begin
            switch = 10'h001;
            sb.push_back('{$sformatf("miss%0d", m), pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd3, 1'b0)});
            step(1);
            e = sb.pop_front(); n_cmp++;
            if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
            switch = 10'd0;
            if (m < 3)
                sb.push_back('{$sformatf("miss_run%0d", m), pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
            else
                sb.push_back('{"game_over", pk(10'h3FF, 4'd0, 4'd1, 2'd0, 3'd5, 1'b1)});
            step(1);
            e = sb.pop_front(); n_cmp++;
            if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        end
        switch = 10'h200;
        sb.push_back('{"over_holds", pk(10'h3FF, 4'd0, 4'd1, 2'd0, 3'd5, 1'b1)});
        step(2);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        switch = 10'd0;
        start = 1'b1;
        sb.push_back('{"restart", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(1);
        start = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
    endtask

    task automatic test_coincide();
        new_game();
        sb.push_back('{"tick7_pos9", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(7);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        switch = 10'h200;
        sb.push_back('{"coincide_hit", pk(10'h200, 4'd0, 4'd0, 2'd0, 3'd2, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        switch = 10'd0;
        sb.push_back('{"coincide_run", pk(10'h200, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        sb.push_back('{"reload_tick", pk(10'h100, 4'd0, 4'd1, 2'd0, 3'd1, 1'b0)});
        step(8);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
    endtask

    task automatic test_reset_mid();
        new_game();
        switch = 10'h200;
        step(1);
        switch = 10'd0;
        step(21);
        #3;
        reset = 1'b1;
        sb.push_back('{"mid_reset", pk(10'd0, 4'd0, 4'd0, 2'd0, 3'd0, 1'b0)});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
        step(2);
        reset = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        sb.push_back('{"post_reset_tick", pk(10'h100, 4'd0, 4'd0, 2'd0, 3'd1, 1'b0)});
        step(8);
        e = sb.pop_front(); n_cmp++;
        if (outs() !== e.val) begin n_bad++; $display("[TB] FAIL %s: got %h want %h", e.name, outs(), e.val); end
    endtask

    initial begin
        $display("[TB] led_game_scheduler bench start");
        test_reset();
        test_step_wrap();
        test_hit();
        test_levels();
        test_over();
        test_coincide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
